pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic replacement for the fixed per-stage pipeline registers between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a WIDTH-bit payload with a valid/ready handshake, stage hold (busywait), synchronous flush (branch/hazard kill) and bubble injection.
- Optional 2-entry skid buffer breaks the combinational ready path.
- Saturating stall-cycle counter for performance analysis.

Parameters:
- WIDTH, 32, payload width in bits (1..256).
- SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY.
- BUBBLE, 32'h00000013, value driven on OUT_DATA when no valid entry is held (RV32 NOP); truncated or zero-extended to WIDTH.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream payload valid.
- IN_READY  out  1  stage can accept this cycle.
- IN_DATA  in  WIDTH  upstream payload.
- OUT_VALID  out  1  downstream payload valid.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  WIDTH  downstream payload.
- HOLD  in  1  freeze stage (memory busywait); no push, no pop.
- FLUSH  in  1  synchronous kill of all held entries.
- COUNT  out  2  occupancy, 0..2 (0..1 when SKID=0).
- STALL_CNT  out  CNT_W  saturating count of stall cycles.
- STALL_CLR  in  1  synchronous clear of STALL_CNT.

Behaviour:
- Storage: main entry (M_V, M_D) drives the output; skid entry (S_V, S_D) exists only when SKID=1.
- Reset (RESET=0, async, immediate, including mid-transfer):
  - M_V = S_V = 0; M_D = S_D = BUBBLE.
  - COUNT = 0; STALL_CNT = 0.
  - IN_READY = 0 while RESET is low; OUT_VALID = 0.
- Outputs:
  - OUT_VALID = M_V & ~HOLD & ~FLUSH.
  - OUT_DATA = M_D when M_V, else BUBBLE.
- Handshakes:
  - push = IN_VALID & IN_READY.
  - pop = OUT_VALID & OUT_READY.
- Ready path:
  - SKID=1: IN_READY = ~S_V & ~HOLD & ~FLUSH. S_V is registered, so there is no combinational path from OUT_READY.
  - SKID=0: IN_READY = (~M_V | OUT_READY) & ~HOLD & ~FLUSH.
- Latency: a pushed payload appears on OUT_DATA/OUT_VALID in the cycle after the push. There is no same-cycle bypass.
- State machine (SKID=1), evaluated on the edge:
  - EMPTY (COUNT 0):
    - push -> ONE, M = IN.
  - ONE (COUNT 1):
    - push & pop -> ONE, M = IN.
    - push only -> TWO, S = IN.
    - pop only -> EMPTY.
    - neither -> hold.
  - TWO (COUNT 2), IN_READY = 0:
    - pop -> ONE, M = S, S_V = 0.
    - no pop -> hold.
  - Order is strictly FIFO; no payload is ever dropped or duplicated outside FLUSH.
- SKID=0 uses EMPTY/ONE only.
  - In ONE with push & pop: M = IN, giving full throughput of 1 transfer/cycle.
- FLUSH (priority over everything except reset):
  - Next state EMPTY; M_D = S_D = BUBBLE.
  - No push or pop occurs in the flush cycle (IN_READY = OUT_VALID = 0 combinationally).
- HOLD:
  - All entries frozen; IN_READY = OUT_VALID = 0.
  - FLUSH & HOLD together -> flush wins.
- STALL_CNT:
  - Increments when (M_V & (HOLD | ~OUT_READY)) & ~FLUSH.
  - Saturates at 2^CNT_W - 1; never wraps.
  - STALL_CLR -> 0 next edge; if STALL_CLR and the increment condition are both true in the same cycle, the clear wins.
- COUNT: equals M_V + S_V; M_V = 0 implies S_V = 0 (invariant the bench must check).
- Throughput requirement: sustained 1 transfer/cycle when OUT_READY = 1 and HOLD = 0, for both SKID values.

Test Plan:
- Reset/idle: RESET low mid-transfer with COUNT=2 -> COUNT=0, OUT_VALID=0, OUT_DATA=32'h00000013 immediately, without waiting for CLK.
- Streaming, SKID=1: IN_DATA = 1,2,3,4 on consecutive cycles with OUT_READY=1 -> OUT_DATA = 1,2,3,4 one cycle later, IN_READY stays 1, COUNT stays 1.
- Backpressure, SKID=1: push 0xA, 0xB with OUT_READY=0 -> COUNT=2, IN_READY=0, STALL_CNT increments each cycle; then OUT_READY=1 -> OUT_DATA 0xA then 0xB, IN_READY returns to 1 after the first pop.
- Flush: COUNT=2 holding 0x10, 0x20; assert FLUSH for one cycle with IN_VALID=1 and IN_DATA=0x30 -> next cycle COUNT=0, OUT_DATA=BUBBLE, 0x30 not accepted.
- Hold: one entry holding 0x55; HOLD=1 for 3 cycles with OUT_READY=1 -> OUT_VALID=0, IN_READY=0, entry retained, STALL_CNT += 3; HOLD=0 -> 0x55 popped.
- SKID=0 and saturation: CNT_W=2, OUT_READY held 0 for 6 cycles -> STALL_CNT stops at 3; STALL_CLR -> 0. Push & pop in the same cycle in ONE -> new data is output the next cycle, COUNT stays 1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake, control and status bundle for one elastic pipeline stage register.
// master drives the stage (upstream/downstream/control side); slave is the stage itself.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic             HOLD;
    logic             FLUSH;
    logic [1:0]       COUNT;
    logic [CNT_W-1:0] STALL_CNT;
    logic             STALL_CLR;

    modport master (
        output IN_VALID, IN_DATA, OUT_READY, HOLD, FLUSH, STALL_CLR,
        input  IN_READY, OUT_VALID, OUT_DATA, COUNT, STALL_CNT
    );

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY, HOLD, FLUSH, STALL_CLR,
        output IN_READY, OUT_VALID, OUT_DATA, COUNT, STALL_CNT
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, hold, flush, bubble output,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SKID   = 1'b1,
    parameter logic [31:0] BUBBLE = 32'h0000_0013,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    pipe_stage_reg_if.slave  stage
);
    localparam logic [WIDTH-1:0] BUB     = WIDTH'(BUBBLE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] m_data_q;
    logic [WIDTH-1:0] s_data_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    logic m_v;
    logic s_v;
    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;
    logic stall_inc;

    assign m_v = (state_q != EMPTY);
    assign s_v = (state_q == TWO);

    always_comb begin
        // Reset gates ready combinationally so nothing is accepted while RESET is low.
        if (SKID) begin
            in_ready = RESET & ~s_v & ~stage.HOLD & ~stage.FLUSH;
        end else begin
            in_ready = RESET & (~m_v | stage.OUT_READY) & ~stage.HOLD & ~stage.FLUSH;
        end
        out_valid = m_v & ~stage.HOLD & ~stage.FLUSH;
        push      = stage.IN_VALID & in_ready;
        pop       = out_valid & stage.OUT_READY;
        stall_inc = m_v & (stage.HOLD | ~stage.OUT_READY) & ~stage.FLUSH;
    end

    always_comb begin
        stall_d = stall_q;
        if (stage.STALL_CLR) begin
            stall_d = '0;
        end else if (stall_inc && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= EMPTY;
            m_data_q <= BUB;
            s_data_q <= BUB;
            stall_q  <= '0;
        end else begin
            stall_q <= stall_d;
            if (stage.FLUSH) begin
                state_q  <= EMPTY;
                m_data_q <= BUB;
                s_data_q <= BUB;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            state_q  <= ONE;
                            m_data_q <= stage.IN_DATA;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            m_data_q <= stage.IN_DATA;
                        end else if (push) begin
                            // Only reachable with the skid entry: without it, push in ONE implies pop.
                            state_q  <= TWO;
                            s_data_q <= stage.IN_DATA;
                        end else if (pop) begin
                            state_q <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            state_q  <= ONE;
                            m_data_q <= s_data_q;
                            s_data_q <= BUB;
                        end
                    end
                    default: begin
                        state_q <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign stage.IN_READY  = in_ready;
    assign stage.OUT_VALID = out_valid;
    assign stage.OUT_DATA  = m_v ? m_data_q : BUB;
    assign stage.COUNT     = state_q;
    assign stage.STALL_CNT = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid (32-bit, 16-bit counter) and
// non-skid (8-bit, 2-bit counter) instances.
module tb_pipe_stage_reg;
    logic CLK;
    logic RESET;
    int   tests;
    int   fails;

    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) a_if ();
    pipe_stage_reg_if #(.WIDTH(8),  .CNT_W(2))  b_if ();

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(32'h0000_0013), .CNT_W(16)) u_a (
        .CLK   (CLK),
        .RESET (RESET),
        .stage (a_if)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1'b0), .BUBBLE(32'h0000_0013), .CNT_W(2)) u_b (
        .CLK   (CLK),
        .RESET (RESET),
        .stage (b_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Occupancy invariants: COUNT never 3, and a visible valid implies a held entry.
    always @(negedge CLK) begin
        if (RESET) begin
            tests++;
            if (a_if.COUNT === 2'd3 || (a_if.OUT_VALID === 1'b1 && a_if.COUNT === 2'd0)) begin
                fails++; $display("FAIL a_invariant: got count=%0d valid=%b", a_if.COUNT, a_if.OUT_VALID);
            end
            tests++;
            if (b_if.COUNT > 2'd1 || (b_if.OUT_VALID === 1'b1 && b_if.COUNT === 2'd0)) begin
                fails++; $display("FAIL b_invariant: got count=%0d valid=%b", b_if.COUNT, b_if.OUT_VALID);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        a_if.IN_VALID = 1'b0; a_if.IN_DATA = '0; a_if.OUT_READY = 1'b0;
        a_if.HOLD = 1'b0; a_if.FLUSH = 1'b0; a_if.STALL_CLR = 1'b0;
        b_if.IN_VALID = 1'b0; b_if.IN_DATA = '0; b_if.OUT_READY = 1'b0;
        b_if.HOLD = 1'b0; b_if.FLUSH = 1'b0; b_if.STALL_CLR = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        idle_all();
        #2;
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL por_count: got %0d exp 0", a_if.COUNT); end
        tests++; if (a_if.OUT_VALID !== 1'b0) begin fails++; $display("FAIL por_valid: got %b exp 0", a_if.OUT_VALID); end
        tests++; if (a_if.OUT_DATA !== 32'h13) begin fails++; $display("FAIL por_data: got %h exp 00000013", a_if.OUT_DATA); end
        tests++; if (a_if.IN_READY !== 1'b0) begin fails++; $display("FAIL por_inready: got %b exp 0", a_if.IN_READY); end
        tests++; if (b_if.OUT_DATA !== 8'h13) begin fails++; $display("FAIL por_b_data: got %h exp 13", b_if.OUT_DATA); end
        #1 RESET = 1'b1;
        tick();
        // Fill to COUNT=2, then reset asynchronously mid-cycle.
        a_if.IN_VALID = 1'b1; a_if.IN_DATA = 32'hA1;
        tick();
        a_if.IN_DATA = 32'hA2;
        tick();
        tests++; if (a_if.COUNT !== 2'd2) begin fails++; $display("FAIL rst_pre_count: got %0d exp 2", a_if.COUNT); end
        a_if.IN_DATA = 32'hA3;
        #1 RESET = 1'b0;
        #1;
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL rst_count: got %0d exp 0", a_if.COUNT); end
        tests++; if (a_if.OUT_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", a_if.OUT_VALID); end
        tests++; if (a_if.OUT_DATA !== 32'h13) begin fails++; $display("FAIL rst_data: got %h exp 00000013", a_if.OUT_DATA); end
        tests++; if (a_if.IN_READY !== 1'b0) begin fails++; $display("FAIL rst_inready: got %b exp 0", a_if.IN_READY); end
        tests++; if (a_if.STALL_CNT !== 16'd0) begin fails++; $display("FAIL rst_stall: got %0d exp 0", a_if.STALL_CNT); end
        idle_all();
        #1 RESET = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        a_if.OUT_READY = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin a_if.IN_VALID = 1'b1; a_if.IN_DATA = 32'(k + 1); end
            else a_if.IN_VALID = 1'b0;
            #1;
            if (k > 0) begin
                tests++; if (a_if.OUT_VALID !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, a_if.OUT_VALID); end
                tests++; if (a_if.OUT_DATA !== 32'(k)) begin fails++; $display("FAIL stream_data[%0d]: got %h exp %h", k, a_if.OUT_DATA, k); end
                tests++; if (a_if.COUNT !== 2'd1) begin fails++; $display("FAIL stream_count[%0d]: got %0d exp 1", k, a_if.COUNT); end
            end
            if (k < 4) begin
                tests++; if (a_if.IN_READY !== 1'b1) begin fails++; $display("FAIL stream_inready[%0d]: got %b exp 1", k, a_if.IN_READY); end
            end
            tick();
        end
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL stream_drain: got %0d exp 0", a_if.COUNT); end
        tests++; if (a_if.STALL_CNT !== 16'd0) begin fails++; $display("FAIL stream_stall: got %0d exp 0", a_if.STALL_CNT); end
        idle_all();
    endtask

    task automatic test_backpressure();
        a_if.IN_VALID = 1'b1; a_if.IN_DATA = 32'hA; a_if.OUT_READY = 1'b0;
        tick();
        a_if.IN_DATA = 32'hB;
        #1;
        tests++; if (a_if.IN_READY !== 1'b1) begin fails++; $display("FAIL bp_inready1: got %b exp 1", a_if.IN_READY); end
        tick();
        a_if.IN_VALID = 1'b0;
        #1;
        tests++; if (a_if.COUNT !== 2'd2) begin fails++; $display("FAIL bp_count2: got %0d exp 2", a_if.COUNT); end
        tests++; if (a_if.IN_READY !== 1'b0) begin fails++; $display("FAIL bp_inready_full: got %b exp 0", a_if.IN_READY); end
        tests++; if (a_if.STALL_CNT !== 16'd1) begin fails++; $display("FAIL bp_stall1: got %0d exp 1", a_if.STALL_CNT); end
        tests++; if (a_if.OUT_DATA !== 32'hA) begin fails++; $display("FAIL bp_head: got %h exp 0000000a", a_if.OUT_DATA); end
        tick();
        tests++; if (a_if.STALL_CNT !== 16'd2) begin fails++; $display("FAIL bp_stall2: got %0d exp 2", a_if.STALL_CNT); end
        a_if.OUT_READY = 1'b1;
        #1;
        tests++; if (a_if.OUT_DATA !== 32'hA || a_if.OUT_VALID !== 1'b1) begin fails++; $display("FAIL bp_pop_a: got %h/%b exp 0000000a/1", a_if.OUT_DATA, a_if.OUT_VALID); end
        tick();
        tests++; if (a_if.OUT_DATA !== 32'hB) begin fails++; $display("FAIL bp_pop_b: got %h exp 0000000b", a_if.OUT_DATA); end
        tests++; if (a_if.COUNT !== 2'd1) begin fails++; $display("FAIL bp_count1: got %0d exp 1", a_if.COUNT); end
        tests++; if (a_if.IN_READY !== 1'b1) begin fails++; $display("FAIL bp_inready_back: got %b exp 1", a_if.IN_READY); end
        tick();
        tests++; if (a_if.COUNT !== 2'd0 || a_if.OUT_DATA !== 32'h13) begin fails++; $display("FAIL bp_empty: got %0d/%h exp 0/00000013", a_if.COUNT, a_if.OUT_DATA); end
        tests++; if (a_if.STALL_CNT !== 16'd2) begin fails++; $display("FAIL bp_stall_final: got %0d exp 2", a_if.STALL_CNT); end
        idle_all();
    endtask

    task automatic test_flush();
        a_if.IN_VALID = 1'b1; a_if.IN_DATA = 32'h10;
        tick();
        a_if.IN_DATA = 32'h20;
        tick();
        tests++; if (a_if.COUNT !== 2'd2) begin fails++; $display("FAIL fl_pre_count: got %0d exp 2", a_if.COUNT); end
        a_if.FLUSH = 1'b1; a_if.IN_DATA = 32'h30;
        #1;
        tests++; if (a_if.IN_READY !== 1'b0 || a_if.OUT_VALID !== 1'b0) begin fails++; $display("FAIL fl_comb: got rdy=%b vld=%b exp 0/0", a_if.IN_READY, a_if.OUT_VALID); end
        tick();
        a_if.FLUSH = 1'b0; a_if.IN_VALID = 1'b0;
        #1;
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL fl_count: got %0d exp 0", a_if.COUNT); end
        tests++; if (a_if.OUT_DATA !== 32'h13 || a_if.OUT_VALID !== 1'b0) begin fails++; $display("FAIL fl_bubble: got %h/%b exp 00000013/0", a_if.OUT_DATA, a_if.OUT_VALID); end
        tests++; if (a_if.STALL_CNT !== 16'd3) begin fails++; $display("FAIL fl_stall: got %0d exp 3", a_if.STALL_CNT); end
        a_if.STALL_CLR = 1'b1;
        tick();
        a_if.STALL_CLR = 1'b0;
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL fl_not_accepted: got %0d exp 0", a_if.COUNT); end
        tests++; if (a_if.STALL_CNT !== 16'd0) begin fails++; $display("FAIL fl_stall_clr: got %0d exp 0", a_if.STALL_CNT); end
        idle_all();
    endtask

    task automatic test_hold();
        a_if.IN_VALID = 1'b1; a_if.IN_DATA = 32'h55; a_if.OUT_READY = 1'b1;
        tick();
        a_if.IN_VALID = 1'b0; a_if.HOLD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (a_if.OUT_VALID !== 1'b0 || a_if.IN_READY !== 1'b0) begin fails++; $display("FAIL hold_block[%0d]: got vld=%b rdy=%b exp 0/0", k, a_if.OUT_VALID, a_if.IN_READY); end
            tests++; if (a_if.COUNT !== 2'd1) begin fails++; $display("FAIL hold_count[%0d]: got %0d exp 1", k, a_if.COUNT); end
            tick();
        end
        a_if.HOLD = 1'b0;
        #1;
        tests++; if (a_if.STALL_CNT !== 16'd3) begin fails++; $display("FAIL hold_stall: got %0d exp 3", a_if.STALL_CNT); end
        tests++; if (a_if.OUT_VALID !== 1'b1 || a_if.OUT_DATA !== 32'h55) begin fails++; $display("FAIL hold_release: got %h/%b exp 00000055/1", a_if.OUT_DATA, a_if.OUT_VALID); end
        tick();
        tests++; if (a_if.COUNT !== 2'd0) begin fails++; $display("FAIL hold_popped: got %0d exp 0", a_if.COUNT); end
        idle_all();
    endtask

    task automatic test_skid0_saturate();
        logic [1:0] exp_cnt;
        b_if.IN_VALID = 1'b1; b_if.IN_DATA = 8'h11; b_if.OUT_READY = 1'b0;
        #1;
        tests++; if (b_if.IN_READY !== 1'b1) begin fails++; $display("FAIL s0_inready_empty: got %b exp 1", b_if.IN_READY); end
        tick();
        b_if.IN_VALID = 1'b0;
        #1;
        tests++; if (b_if.IN_READY !== 1'b0) begin fails++; $display("FAIL s0_inready_full: got %b exp 0", b_if.IN_READY); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_cnt = (k < 3) ? 2'(k) : 2'd3;
            tests++; if (b_if.STALL_CNT !== exp_cnt) begin fails++; $display("FAIL s0_sat[%0d]: got %0d exp %0d", k, b_if.STALL_CNT, exp_cnt); end
        end
        b_if.STALL_CLR = 1'b1;
        tick();
        b_if.STALL_CLR = 1'b0;
        tests++; if (b_if.STALL_CNT !== 2'd0) begin fails++; $display("FAIL s0_clr_wins: got %0d exp 0", b_if.STALL_CNT); end
        b_if.OUT_READY = 1'b1; b_if.IN_VALID = 1'b1; b_if.IN_DATA = 8'h22;
        #1;
        tests++; if (b_if.IN_READY !== 1'b1 || b_if.OUT_DATA !== 8'h11) begin fails++; $display("FAIL s0_pushpop: got rdy=%b data=%h exp 1/11", b_if.IN_READY, b_if.OUT_DATA); end
        tick();
        b_if.IN_DATA = 8'h33;
        #1;
        tests++; if (b_if.OUT_DATA !== 8'h22 || b_if.COUNT !== 2'd1) begin fails++; $display("FAIL s0_next1: got %h/%0d exp 22/1", b_if.OUT_DATA, b_if.COUNT); end
        tick();
        b_if.IN_VALID = 1'b0;
        #1;
        tests++; if (b_if.OUT_DATA !== 8'h33 || b_if.COUNT !== 2'd1) begin fails++; $display("FAIL s0_next2: got %h/%0d exp 33/1", b_if.OUT_DATA, b_if.COUNT); end
        tick();
        tests++; if (b_if.COUNT !== 2'd0 || b_if.OUT_DATA !== 8'h13) begin fails++; $display("FAIL s0_empty: got %0d/%h exp 0/13", b_if.COUNT, b_if.OUT_DATA); end
        tests++; if (b_if.STALL_CNT !== 2'd0) begin fails++; $display("FAIL s0_stall_idle: got %0d exp 0", b_if.STALL_CNT); end
        idle_all();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold();
        test_skid0_saturate();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
